command_parser: RTL and testbench

Parametrised multi-character command parser for the UART console path. It takes a fixed-width ASCII line buffer, scans it one character per clock, matches a case-insensitive keyword, and extracts up to two hex operands. Results are delivered over a valid/ready handshake. It sits between the line-buffer assembler and the top-level mode controller, and replaces single-character command decoding.

---
 rtl/command_pkg.sv | 84 ++++++++
 rtl/command_parser_char_classify.sv | 27 ++
 rtl/command_parser.sv | 225 ++++++++++++++++++++++
 tb/tb_command_parser.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/command_pkg.sv
// Shared constants, keyword table and helper types for the console command parser.
package command_pkg;

  localparam int unsigned KW_MAX = 5;
  localparam int unsigned NUM_KW = 4;
  localparam int unsigned KP_W   = 3;

  localparam logic [2:0] CMD_CPU     = 3'd0;
  localparam logic [2:0] CMD_ALU     = 3'd1;
  localparam logic [2:0] CMD_BENCH   = 3'd2;
  localparam logic [2:0] CMD_HELP    = 3'd3;
  localparam logic [2:0] CMD_INVALID = 3'd7;

  localparam logic [2:0] STAT_OK            = 3'd0;
  localparam logic [2:0] STAT_UNKNOWN       = 3'd1;
  localparam logic [2:0] STAT_BAD_CHAR      = 3'd2;
  localparam logic [2:0] STAT_OVERFLOW      = 3'd3;
  localparam logic [2:0] STAT_TOO_MANY_ARGS = 3'd4;
  localparam logic [2:0] STAT_EMPTY         = 3'd5;

  localparam logic [7:0] CH_NUL   = 8'h00;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_KEYWORD = 2'd1,
    ST_ARG     = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef logic [NUM_KW-1:0] kw_mask_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] code;
  } kw_match_t;

  // Keyword text, NUL padded; table index equals the command code.
  function automatic logic [8*KW_MAX-1:0] kw_text(input int unsigned k);
    case (k)
      0:       return {"CPU", 16'h0000};
      1:       return {"ALU", 16'h0000};
      2:       return "BENCH";
      3:       return {"HELP", 8'h00};
      default: return '0;
    endcase
  endfunction

  function automatic logic [KP_W-1:0] kw_len(input int unsigned k);
    case (k)
      0:       return KP_W'(3);
      1:       return KP_W'(3);
      2:       return KP_W'(5);
      3:       return KP_W'(4);
      default: return '0;
    endcase
  endfunction

  function automatic logic [7:0] kw_char(input int unsigned k, input logic [KP_W-1:0] p);
    logic [8*KW_MAX-1:0] text;
    logic [7:0]          ch;
    text = kw_text(k);
    ch   = CH_NUL;
    for (int unsigned i = 0; i < KW_MAX; i++) begin
      if (KP_W'(i) == p) ch = text[8*(KW_MAX-1-i) +: 8];
    end
    return ch;
  endfunction

  // Surviving candidate whose length equals the number of letters seen.
  function automatic kw_match_t kw_lookup(input kw_mask_t mask, input logic [KP_W-1:0] len);
    kw_match_t m;
    m = '0;
    for (int unsigned k = 0; k < NUM_KW; k++) begin
      if (mask[k] && (kw_len(k) == len)) begin
        m.hit  = 1'b1;
        m.code = 3'(k);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/command_parser_char_classify.sv
// Combinational byte classifier: case folding, hex decode, separator/terminator detection.
module char_classify
  import command_pkg::*;
(
  input  logic [7:0] ch,
  output logic [7:0] upper,
  output logic       is_letter,
  output logic       is_hex,
  output logic [3:0] nibble,
  output logic       is_space,
  output logic       is_term
);

  logic is_digit;

  always_comb begin
    upper = ch;
    if ((ch >= 8'h61) && (ch <= 8'h7A)) upper = ch - 8'h20;
    is_letter = (upper >= 8'h41) && (upper <= 8'h5A);
    is_digit  = (ch >= 8'h30) && (ch <= 8'h39);
    is_hex    = is_digit || ((upper >= 8'h41) && (upper <= 8'h46));
    nibble    = is_digit ? 4'(ch - 8'h30) : 4'(upper - 8'h37);
    is_space  = (ch == CH_SPACE);
    is_term   = (ch == CH_NUL) || (ch == CH_CR);
  end

endmodule

// File: rtl/command_parser.sv
// Console command parser: scans an ASCII line one character per clock, matches a
// keyword and up to two hex operands, and returns the result over valid/ready.
module command_parser
  import command_pkg::*;
#(
  parameter int unsigned BUF_CHARS = 16,
  parameter int unsigned OP_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*BUF_CHARS-1:0] buffer,
  input  logic                   buffer_valid,
  output logic                   buffer_ready,
  output logic [2:0]             command,
  output logic [OP_WIDTH-1:0]    operand_a,
  output logic [OP_WIDTH-1:0]    operand_b,
  output logic [1:0]             arg_count,
  output logic [2:0]             status,
  output logic                   command_valid,
  input  logic                   command_ready
);

  localparam int unsigned POS_W    = (BUF_CHARS > 1) ? $clog2(BUF_CHARS) : 1;
  localparam int unsigned MAX_DIG  = OP_WIDTH / 4;
  localparam int unsigned DIG_W    = $clog2(MAX_DIG + 1);
  localparam int unsigned LINE_W   = 8 * BUF_CHARS;

  state_t                state_q, state_n;
  logic [LINE_W-1:0]     line_q;
  logic [POS_W-1:0]      pos_q;
  logic [KP_W-1:0]       kp_q, kp_n;
  kw_mask_t              cand_q, cand_n;
  logic [DIG_W-1:0]      dig_q, dig_n;
  logic                  in_op_q, in_op_n;
  logic [2:0]            cmd_sel_q, cmd_sel_n;
  logic [OP_WIDTH-1:0]   op_a_q, op_a_n, op_b_q, op_b_n;
  logic [1:0]            arg_q, arg_n;
  logic                  fin, to_arg;
  logic [2:0]            fin_stat;
  kw_match_t             hit;

  logic [7:0] cc_upper;
  logic       cc_letter, cc_hex, cc_space, cc_term;
  logic [3:0] cc_nibble;
  logic       last, accept, consume, scanning;

  char_classify u_classify (
    .ch        (line_q[LINE_W-1 -: 8]),
    .upper     (cc_upper),
    .is_letter (cc_letter),
    .is_hex    (cc_hex),
    .nibble    (cc_nibble),
    .is_space  (cc_space),
    .is_term   (cc_term)
  );

  assign last     = (pos_q == POS_W'(BUF_CHARS - 1));
  assign accept   = (state_q == ST_IDLE) && buffer_valid;
  assign consume  = (state_q == ST_DONE) && command_ready;
  assign scanning = (state_q == ST_KEYWORD) || (state_q == ST_ARG);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  // Next state.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:    if (buffer_valid) state_n = ST_KEYWORD;
      ST_KEYWORD: if (fin) state_n = ST_DONE; else if (to_arg) state_n = ST_ARG;
      ST_ARG:     if (fin) state_n = ST_DONE;
      ST_DONE:    if (command_ready) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    buffer_ready = (state_q == ST_IDLE);
  end

  // Per-character scan step; the last buffer position also acts as a terminator.
  always_comb begin
    kp_n      = kp_q;
    cand_n    = cand_q;
    dig_n     = dig_q;
    in_op_n   = in_op_q;
    cmd_sel_n = cmd_sel_q;
    op_a_n    = op_a_q;
    op_b_n    = op_b_q;
    arg_n     = arg_q;
    fin       = 1'b0;
    fin_stat  = STAT_OK;
    to_arg    = 1'b0;
    hit       = '0;
    case (state_q)
      ST_KEYWORD: begin
        if (cc_space && (kp_q == '0)) begin
          if (last) begin
            fin      = 1'b1;
            fin_stat = STAT_EMPTY;
          end
        end else if (cc_letter) begin
          for (int unsigned k = 0; k < NUM_KW; k++) begin
            cand_n[k] = cand_q[k] && (kp_q < KP_W'(KW_MAX)) && (kw_len(k) > kp_q)
                        && (kw_char(k, kp_q) == cc_upper);
          end
          if (kp_q < KP_W'(KW_MAX + 1)) kp_n = kp_q + KP_W'(1);
          if (last) begin
            hit       = kw_lookup(cand_n, kp_n);
            cmd_sel_n = hit.code;
            fin       = 1'b1;
            fin_stat  = hit.hit ? STAT_OK : STAT_UNKNOWN;
          end
        end else if ((cc_space || cc_term) && (kp_q != '0)) begin
          hit       = kw_lookup(cand_q, kp_q);
          cmd_sel_n = hit.code;
          if (!hit.hit) begin
            fin      = 1'b1;
            fin_stat = STAT_UNKNOWN;
          end else if (cc_term || last) begin
            fin = 1'b1;
          end else begin
            to_arg = 1'b1;
          end
        end else if (cc_term) begin
          fin      = 1'b1;
          fin_stat = STAT_EMPTY;
        end else begin
          fin      = 1'b1;
          fin_stat = STAT_BAD_CHAR;
        end
      end
      ST_ARG: begin
        if (cc_space) begin
          if (in_op_q) begin
            arg_n   = arg_q + 2'd1;
            in_op_n = 1'b0;
            dig_n   = '0;
          end
          if (last) fin = 1'b1;
        end else if (cc_term) begin
          if (in_op_q) arg_n = arg_q + 2'd1;
          fin = 1'b1;
        end else if (cc_hex) begin
          if (!in_op_q && (arg_q == 2'd2)) begin
            fin      = 1'b1;
            fin_stat = STAT_TOO_MANY_ARGS;
          end else if (dig_q == DIG_W'(MAX_DIG)) begin
            fin      = 1'b1;
            fin_stat = STAT_OVERFLOW;
          end else begin
            if (arg_q == 2'd0) op_a_n = (op_a_q << 4) | OP_WIDTH'(cc_nibble);
            else               op_b_n = (op_b_q << 4) | OP_WIDTH'(cc_nibble);
            dig_n   = dig_q + DIG_W'(1);
            in_op_n = 1'b1;
            if (last) begin
              arg_n = arg_q + 2'd1;
              fin   = 1'b1;
            end
          end
        end else begin
          fin      = 1'b1;
          fin_stat = STAT_BAD_CHAR;
        end
      end
      default: ;
    endcase
  end

  // Line shift register, scan context and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q        <= '0;
      pos_q         <= '0;
      kp_q          <= '0;
      cand_q        <= '0;
      dig_q         <= '0;
      in_op_q       <= 1'b0;
      cmd_sel_q     <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      arg_q         <= '0;
      command       <= '0;
      status        <= '0;
      command_valid <= 1'b0;
    end else if (accept) begin
      line_q  <= buffer;
      pos_q   <= '0;
      kp_q    <= '0;
      cand_q  <= '1;
      dig_q   <= '0;
      in_op_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      arg_q   <= '0;
    end else if (scanning) begin
      line_q    <= line_q << 8;
      pos_q     <= pos_q + POS_W'(1);
      kp_q      <= kp_n;
      cand_q    <= cand_n;
      dig_q     <= dig_n;
      in_op_q   <= in_op_n;
      cmd_sel_q <= cmd_sel_n;
      op_a_q    <= op_a_n;
      op_b_q    <= op_b_n;
      arg_q     <= arg_n;
      if (fin) begin
        command       <= (fin_stat == STAT_OK) ? cmd_sel_n : CMD_INVALID;
        status        <= fin_stat;
        command_valid <= 1'b1;
      end
    end else if (consume) begin
      command_valid <= 1'b0;
    end
  end

  assign operand_a = op_a_q;
  assign operand_b = op_b_q;
  assign arg_count = arg_q;

endmodule

// File: tb/tb_command_parser.sv
// Scoreboard bench for command_parser: directed lines with hand-computed results.
module tb_command_parser;
  import command_pkg::*;

  localparam int unsigned BUF_CHARS = 16;
  localparam int unsigned OP_WIDTH  = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [8*BUF_CHARS-1:0] buffer;
  logic                   buffer_valid;
  logic                   buffer_ready;
  logic [2:0]             command;
  logic [OP_WIDTH-1:0]    operand_a, operand_b;
  logic [1:0]             arg_count;
  logic [2:0]             status;
  logic                   command_valid;
  logic                   command_ready;

  command_parser #(.BUF_CHARS(BUF_CHARS), .OP_WIDTH(OP_WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .buffer        (buffer),
    .buffer_valid  (buffer_valid),
    .buffer_ready  (buffer_ready),
    .command       (command),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .arg_count     (arg_count),
    .status        (status),
    .command_valid (command_valid),
    .command_ready (command_ready)
  );

  typedef struct {
    string       name;
    logic [2:0]  cmd;
    logic [2:0]  st;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  n;
    int          k;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   seen     = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [8*BUF_CHARS-1:0] make_buf(input string s);
    logic [8*BUF_CHARS-1:0] b;
    b = '0;
    for (int i = 0; i < BUF_CHARS; i++) begin
      if (i < s.len()) b[8*(BUF_CHARS-1-i) +: 8] = s[i];
    end
    return b;
  endfunction

  // Latency monitor: edges from accept to the rise of command_valid.
  always @(posedge clk) begin
    #1;
    if (command_valid && !seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: actual command_valid 1 required no pending result");
      end else begin
        check({sb[0].name, " latency"}, 32'(cyc - sb[0].acc), 32'(sb[0].k));
      end
    end else if (!command_valid) begin
      seen = 1'b0;
    end
  end

  // Result monitor: compares at every handshake that will consume a result.
  always @(negedge clk) begin
    if (!rst && command_valid && command_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: actual command %0h required no pending result", command);
      end else begin
        check({sb[0].name, " command"},   32'(command),   32'(sb[0].cmd));
        check({sb[0].name, " status"},    32'(status),    32'(sb[0].st));
        check({sb[0].name, " operand_a"}, 32'(operand_a), 32'(sb[0].a));
        check({sb[0].name, " operand_b"}, 32'(operand_b), 32'(sb[0].b));
        check({sb[0].name, " arg_count"}, 32'(arg_count), 32'(sb[0].n));
        void'(sb.pop_front());
      end
    end
  end

  task automatic wait_ready(input string name);
    int t = 0;
    while (!buffer_ready && t < 60) begin
      @(posedge clk); #2;
      t++;
    end
    if (!buffer_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s ready_timeout: actual buffer_ready 0 required 1", name);
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s result_timeout: actual %0d pending required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic send(input string name, input logic [8*BUF_CHARS-1:0] line,
                      input logic [2:0] cmd, input logic [2:0] st,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] n, input int k);
    exp_t e;
    wait_ready(name);
    buffer       = line;
    buffer_valid = 1'b1;
    @(posedge clk); #1;
    e = '{name, cmd, st, a, b, n, k, cyc};
    sb.push_back(e);
    #1 buffer_valid = 1'b0;
    drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8*BUF_CHARS-1:0] bv;
    exp_t e;
    int   t;

    rst           = 1'b1;
    buffer        = '0;
    buffer_valid  = 1'b0;
    command_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset buffer_ready",  32'(buffer_ready),  32'd1);
    check("reset command_valid", 32'(command_valid), 32'd0);
    check("reset command",       32'(command),       32'd0);
    check("reset status",        32'(status),        32'd0);
    check("reset operand_a",     32'(operand_a),     32'd0);
    check("reset operand_b",     32'(operand_b),     32'd0);
    check("reset arg_count",     32'(arg_count),     32'd0);
    rst = 1'b0;
    @(posedge clk); #2;

    send("alu2",     make_buf("ALU 1F 3"),  CMD_ALU,     STAT_OK,            16'h001F, 16'h0003, 2'd2, 9);
    send("bench",    make_buf("bench"),     CMD_BENCH,   STAT_OK,            16'h0000, 16'h0000, 2'd0, 6);
    send("al",       make_buf("AL"),        CMD_INVALID, STAT_UNKNOWN,       16'h0000, 16'h0000, 2'd0, 3);
    send("alux",     make_buf("ALUX"),      CMD_INVALID, STAT_UNKNOWN,       16'h0000, 16'h0000, 2'd0, 5);
    send("cpx",      make_buf("CPX"),       CMD_INVALID, STAT_UNKNOWN,       16'h0000, 16'h0000, 2'd0, 4);
    send("empty",    make_buf(""),          CMD_INVALID, STAT_EMPTY,         16'h0000, 16'h0000, 2'd0, 1);
    send("overflow", make_buf("CPU 12345"), CMD_INVALID, STAT_OVERFLOW,      16'h1234, 16'h0000, 2'd0, 9);
    send("toomany",  make_buf("CPU 1 2 3"), CMD_INVALID, STAT_TOO_MANY_ARGS, 16'h0001, 16'h0002, 2'd2, 9);
    send("badhex",   make_buf("CPU 1G"),    CMD_INVALID, STAT_BAD_CHAR,      16'h0001, 16'h0000, 2'd0, 6);
    send("badkw",    make_buf("?"),         CMD_INVALID, STAT_BAD_CHAR,      16'h0000, 16'h0000, 2'd0, 1);
    send("badarg",   make_buf("ALU 1!"),    CMD_INVALID, STAT_BAD_CHAR,      16'h0001, 16'h0000, 2'd0, 6);
    send("sixlet",   make_buf("BENCHX"),    CMD_INVALID, STAT_UNKNOWN,       16'h0000, 16'h0000, 2'd0, 7);
    send("maxdig",   make_buf("ALU FFFF"),  CMD_ALU,     STAT_OK,            16'hFFFF, 16'h0000, 2'd1, 9);
    send("help_end", make_buf("HELP            "), CMD_HELP, STAT_OK,        16'h0000, 16'h0000, 2'd0, 16);
    send("digit_end", make_buf("ALU 12      ABCD"), CMD_ALU, STAT_OK,        16'h0012, 16'hABCD, 2'd2, 16);
    bv = make_buf(" cpu ab  cd");
    bv[8*(BUF_CHARS-1-11) +: 8] = CH_CR;
    send("lower_cr", bv, CMD_CPU, STAT_OK, 16'h00AB, 16'h00CD, 2'd2, 12);

    // Backpressure: result held for 10 cycles while a second line waits.
    command_ready = 1'b0;
    wait_ready("bp");
    buffer       = make_buf("CPU 5");
    buffer_valid = 1'b1;
    @(posedge clk); #1;
    e = '{"bp_first", CMD_CPU, STAT_OK, 16'h0005, 16'h0000, 2'd1, 6, cyc};
    sb.push_back(e);
    #1 buffer = make_buf("HELP 7");
    t = 0;
    while (!command_valid && t < 40) begin
      @(posedge clk); #2;
      t++;
    end
    check("bp valid_reached", 32'(command_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      check("bp hold command_valid", 32'(command_valid), 32'd1);
      check("bp hold command",       32'(command),       32'(CMD_CPU));
      check("bp hold operand_a",     32'(operand_a),     32'h5);
      check("bp hold buffer_ready",  32'(buffer_ready),  32'd0);
    end
    command_ready = 1'b1;
    @(posedge clk); #1;
    check("bp ready_after_consume", 32'(buffer_ready), 32'd1);
    @(posedge clk); #1;
    e = '{"bp_second", CMD_HELP, STAT_OK, 16'h0007, 16'h0000, 2'd1, 7, cyc};
    sb.push_back(e);
    #1 buffer_valid = 1'b0;
    drain("bp_second");

    // Reset in the middle of a scan.
    wait_ready("rst");
    buffer       = make_buf("ALU 1F");
    buffer_valid = 1'b1;
    @(posedge clk); #1;
    #1 buffer_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy buffer_ready", 32'(buffer_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("rst buffer_ready",  32'(buffer_ready),  32'd1);
    check("rst command_valid", 32'(command_valid), 32'd0);
    check("rst command",       32'(command),       32'd0);
    check("rst status",        32'(status),        32'd0);
    check("rst operand_a",     32'(operand_a),     32'd0);
    check("rst arg_count",     32'(arg_count),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #2;
    send("after_rst", make_buf("CPU"), CMD_CPU, STAT_OK, 16'h0000, 16'h0000, 2'd0, 4);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
